sprite_line_mixer: RTL
======================

Name: sprite_line_mixer

Overview:
- Per-scanline sprite pixel mixer for the NES PPU.
- Holds up to SLOTS sprites for the current line. Each slot is loaded in 32-bit evaluated format during the previous line's hblank.
- On each pixel strobe, selects the highest-priority opaque sprite pixel and merges it with the background colour.
- Produces a registered colour, a hit flag and a sticky sprite-0-hit flag. Sits between the OAM evaluation stage and the palette lookup.

Parameters:
- SLOTS, 8, number of sprite slots per line; slot 0 has highest priority.
- IDXW, 3, width of the slot index; must satisfy 2^IDXW >= SLOTS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- line_start  in  1  one-cycle pulse; invalidates all slots.
- frame_start  in  1  one-cycle pulse; clears sprite0_hit.
- load  in  1  write strobe for one slot.
- load_idx  in  IDXW  slot to write.
- load_data  in  32  sprite word, laid out as follows:
  - [7:0] X position.
  - [15:8] pattern plane 0, MSB = leftmost pixel.
  - [23:16] attributes: [1:0] palette, [5] behind-background, [6] horizontal flip.
  - [31:24] pattern plane 1, MSB = leftmost pixel.
- load_s0  in  1  the word being loaded is OAM sprite 0.
- pix_en  in  1  pixel strobe.
- x  in  9  current pixel X, sampled on pix_en.
- bg  in  5  background colour at x; bg[1:0]==0 means transparent.
- ctrl  in  8  PPUMASK copy: [2] show sprites in columns 0-7, [4] sprite enable.
- color  out  5  mixed colour; color[4]=1 when the colour comes from a sprite.
- hit  out  1  an opaque sprite pixel exists at x, before the priority/behind-bg decision.
- color_vld  out  1  color/hit updated this cycle.
- sprite0_hit  out  1  sticky sprite-0 hit.
- overflow  out  1  a load was addressed to load_idx >= SLOTS since the last line_start.

Behaviour:
- Reset:
  - All slot valid bits clear, all s0 tags clear.
  - color=0, hit=0, color_vld=0, sprite0_hit=0, overflow=0.
- Slot storage: per slot, x (8 bits), plane0/plane1 (8 bits each), palette (2), behind (1), hflip (1), s0 tag (1), valid (1).
- load with load_idx < SLOTS: writes that slot, sets its valid bit and s0 tag = load_s0.
- load with load_idx >= SLOTS: no write, sets overflow.
- line_start:
  - Clears every valid bit and overflow.
  - If load occurs in the same cycle, the load is applied after the clear: the addressed slot ends valid, and overflow ends set if the index is out of range.
- Pixel evaluation, on pix_en:
  - Per slot, compute off = x - slot.x in 9-bit arithmetic.
  - The slot is in range when slot.x <= x < slot.x + 8, with the sum computed in 9 bits, so a sprite at X=250 covers 250..257.
  - Bit select: bit = 7 - off[2:0], or off[2:0] when hflip is set.
  - Pixel = {plane1[bit], plane0[bit]}; the pixel is opaque when it is non-zero.
- Priority: the lowest-index valid, in-range, opaque slot wins. Its palette and pixel form rc[3:0] = {palette, pixel}.
- Clipping: if ctrl[4]==0, or (ctrl[2]==0 and x<8), no slot is considered: hit=0 and color=bg.
- Mixing:
  - No winner: color=bg, hit=0.
  - Winner with behind=1 and bg[1:0]!=0: color=bg, hit=1.
  - Otherwise: color={1'b1, rc}, hit=1.
  - Only the winner's behind bit matters. A lower-priority front sprite does not show through a higher-priority behind sprite.
- sprite0_hit is set when all of the following hold on a pix_en:
  - A valid s0-tagged slot is opaque at x. It need not be the winner.
  - bg[1:0]!=0.
  - x != 255.
  - The pixel is not clipped.
- sprite0_hit holds until frame_start or rst. If frame_start and a set condition coincide, the set wins.
- Latency:
  - color, hit and color_vld are registered; results appear exactly 1 cycle after pix_en. color_vld is a 1-cycle pulse.
  - Without pix_en, color and hit hold their last values.
- Consecutive pix_en on every clock is fully supported (throughput 1 pixel/clk).
- A load during pixel evaluation is allowed. A pix_en in the same cycle as a load sees the pre-load contents of that slot.

Optional Feature:
- Macro SPR_HFLIP_EN.
- Defined: attribute bit 6 mirrors the sprite horizontally, as above.
- Undefined: bit 6 is ignored, bit = 7 - off[2:0] always, and no flip logic is generated.

Test Plan:
- Sprite X=16, plane0=0x80, plane1=0x00, palette=2, slot 3; ctrl=0x14; pix_en at x=16 with bg=0 → next cycle color=5'b11001, hit=1, color_vld=1. At x=17 → color=bg, hit=0.
- Slot 0 (X=10, behind=1, all pixels opaque) and slot 1 (X=10, front, palette 1); x=12, bg=5'b00011 → color=bg, hit=1. Repeat with bg=5'b00000 → slot 0 colour shown.
- Clipping: sprite at X=0, ctrl=0x10, x=3 → color=bg, hit=0, sprite0_hit stays 0. With ctrl=0x14 → sprite colour.
- Sprite 0 (load_s0=1) at X=255 opaque, bg opaque: x=255 → sprite0_hit stays 0. Sprite 0 at X=100, x=101 → sprite0_hit=1 from the cycle after, held across line_start, cleared by frame_start.
- Wrap and flip: X=250, plane0=0x01, hflip=1, x=250 → opaque (SPR_HFLIP_EN defined), transparent when undefined. x=257 → in range, bit per flip rule.
- Overflow and reset: load_idx=SLOTS → overflow=1, no slot written. line_start → overflow=0. Assert rst mid-line → all outputs 0 asynchronously, and a pix_en after release yields color=bg.

Source files
------------

// File: rtl/sprite_line_mixer.sv
// Per-scanline sprite pixel mixer: picks the highest-priority opaque sprite pixel and merges it with the background.
// Optional macro SPR_HFLIP_EN enables horizontal flip via attribute bit 6.
module sprite_line_mixer #(
   parameter int SLOTS = 8,
   parameter int IDXW  = 3
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_line_start,
   input  logic            i_frame_start,
   input  logic            i_load,
   input  logic [IDXW-1:0] i_load_idx,
   input  logic [31:0]     i_load_data,
   input  logic            i_load_s0,
   input  logic            i_pix_en,
   input  logic [8:0]      i_x,
   input  logic [4:0]      i_bg,
   input  logic [7:0]      i_ctrl,
   output logic [4:0]      o_color,
   output logic            o_hit,
   output logic            o_color_vld,
   output logic            o_sprite0_hit,
   output logic            o_overflow
);

   logic [7:0]       r_sx     [SLOTS];
   logic [7:0]       r_p0     [SLOTS];
   logic [7:0]       r_p1     [SLOTS];
   logic [1:0]       r_pal    [SLOTS];
   logic [SLOTS-1:0] r_behind;
   logic [SLOTS-1:0] r_s0;
   logic [SLOTS-1:0] r_valid;
`ifdef SPR_HFLIP_EN
   logic [SLOTS-1:0] r_hflip;
`endif

   logic [SLOTS-1:0] w_opq;
   logic [1:0]       w_pixArr [SLOTS];
   logic             w_loadOob;
   logic             w_clip;
   logic             w_bgOpq;
   logic             w_found;
   logic [3:0]       w_rc;
   logic             w_winBehind;
   logic [4:0]       w_nextColor;
   logic             w_nextHit;
   logic             w_s0Set;
   logic             w_unusedBits;

`ifdef SPR_HFLIP_EN
   assign w_unusedBits = ^{i_load_data[20:18], i_load_data[23], i_ctrl[7:5], i_ctrl[3], i_ctrl[1:0]};
`else
   assign w_unusedBits = ^{i_load_data[23:22], i_load_data[20:18], i_ctrl[7:5], i_ctrl[3], i_ctrl[1:0]};
`endif

   assign w_loadOob = ({1'b0, i_load_idx} >= (IDXW+1)'(SLOTS));
   assign w_clip    = !i_ctrl[4] || (!i_ctrl[2] && (i_x < 9'd8));
   assign w_bgOpq   = |i_bg[1:0];

   // Only the low three bits of x - slot.x are needed to pick the pattern bit.
   for (genvar g = 0; g < SLOTS; g++) begin : gSlot
      logic [2:0] w_off;
      logic [2:0] w_bit;
      logic [1:0] w_pix;
      logic       w_inRange;
      assign w_off     = i_x[2:0] - r_sx[g][2:0];
      assign w_inRange = (i_x >= {1'b0, r_sx[g]}) && (i_x < ({1'b0, r_sx[g]} + 9'd8));
`ifdef SPR_HFLIP_EN
      assign w_bit     = r_hflip[g] ? w_off : (3'd7 - w_off);
`else
      assign w_bit     = 3'd7 - w_off;
`endif
      assign w_pix       = {r_p1[g][w_bit], r_p0[g][w_bit]};
      assign w_pixArr[g] = w_pix;
      assign w_opq[g]    = r_valid[g] && w_inRange && (w_pix != 2'b00);
   end

   // Scan from the lowest priority upward so the lowest opaque index is the last to assign.
   always_comb begin
      w_found     = 1'b0;
      w_rc        = 4'd0;
      w_winBehind = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (w_opq[i]) begin
            w_found     = 1'b1;
            w_rc        = {r_pal[i], w_pixArr[i]};
            w_winBehind = r_behind[i];
         end
      end
   end

   always_comb begin
      w_nextColor = i_bg;
      w_nextHit   = 1'b0;
      if (!w_clip && w_found) begin
         w_nextHit = 1'b1;
         if (!(w_winBehind && w_bgOpq)) begin
            w_nextColor = {1'b1, w_rc};
         end
      end
   end

   assign w_s0Set = i_pix_en && !w_clip && w_bgOpq && (i_x != 9'd255) && |(w_opq & r_s0);

   // A same-cycle line_start clears first, so a simultaneous load still lands.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid    <= '0;
         r_s0       <= '0;
         r_behind   <= '0;
         o_overflow <= 1'b0;
`ifdef SPR_HFLIP_EN
         r_hflip    <= '0;
`endif
         for (int i = 0; i < SLOTS; i++) begin
            r_sx[i]  <= 8'd0;
            r_p0[i]  <= 8'd0;
            r_p1[i]  <= 8'd0;
            r_pal[i] <= 2'd0;
         end
      end else begin
         if (i_line_start) begin
            r_valid    <= '0;
            o_overflow <= 1'b0;
         end
         if (i_load && w_loadOob) begin
            o_overflow <= 1'b1;
         end
         for (int i = 0; i < SLOTS; i++) begin
            if (i_load && (i_load_idx == IDXW'(i))) begin
               r_sx[i]     <= i_load_data[7:0];
               r_p0[i]     <= i_load_data[15:8];
               r_pal[i]    <= i_load_data[17:16];
               r_behind[i] <= i_load_data[21];
               r_p1[i]     <= i_load_data[31:24];
               r_s0[i]     <= i_load_s0;
               r_valid[i]  <= 1'b1;
`ifdef SPR_HFLIP_EN
               r_hflip[i]  <= i_load_data[22];
`endif
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_color       <= 5'd0;
         o_hit         <= 1'b0;
         o_color_vld   <= 1'b0;
         o_sprite0_hit <= 1'b0;
      end else begin
         o_color_vld <= i_pix_en;
         if (i_pix_en) begin
            o_color <= w_nextColor;
            o_hit   <= w_nextHit;
         end
         if (w_s0Set) begin
            o_sprite0_hit <= 1'b1;
         end else if (i_frame_start) begin
            o_sprite0_hit <= 1'b0;
         end
      end
   end

endmodule
